// File: rtl/mem_access_if.sv
// Request, response and data-memory signals of the load/store unit.
// The unit uses the slave modport; the execute stage and memory use master.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic [11:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_is_load;
    logic        rsp_exc;
    logic [4:0]  rsp_exc_code;
    logic [31:0] rsp_badvaddr;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  dm_dout, rsp_ready,
        output req_ready, dm_addr, dm_be, dm_din, dm_we,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_is_load, rsp_exc, rsp_exc_code, rsp_badvaddr
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output dm_dout, rsp_ready,
        input  req_ready, dm_addr, dm_be, dm_din, dm_we,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_is_load, rsp_exc, rsp_exc_code, rsp_badvaddr
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, alignment/range checking, a single
// registered memory access cycle and an extended response held until accepted.
module mem_access_unit (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic        illegal;
    logic        lat_we;
    logic        lat_uns;
    logic [1:0]  lat_size;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // The memory returns the selected lane right-justified, so only the
    // width and signedness matter here, not the byte offset.
    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                                input logic [31:0] dout);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = dout[7:0];
        h = dout[15:0];
        case (size)
            2'b00: begin
                s = b;
                extend_load = uns ? {24'h0, dout[7:0]} : s;
            end
            2'b01: begin
                s = h;
                extend_load = uns ? {16'h0, dout[15:0]} : s;
            end
            default: extend_load = dout;
        endcase
    endfunction

    assign misaligned   = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign out_of_range = (bus.req_addr[31:14] != 18'h0) || (bus.req_addr[13:2] >= 12'd3072);
    assign illegal      = misaligned || out_of_range;
    assign accept       = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    state_nxt = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we   <= bus.req_we;
            lat_uns  <= bus.req_unsigned;
            lat_size <= bus.req_size;
        end
    end

    // Memory strobes are pulsed for exactly the ACCESS cycle; address and
    // data hold their last values so the memory inputs never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dm_addr      <= 12'h0;
            bus.dm_be        <= 4'h0;
            bus.dm_din       <= 32'h0;
            bus.dm_we        <= 1'b0;
            bus.rsp_rdata    <= 32'h0;
            bus.rsp_rd       <= 5'h0;
            bus.rsp_is_load  <= 1'b0;
            bus.rsp_exc      <= 1'b0;
            bus.rsp_exc_code <= 5'h0;
            bus.rsp_badvaddr <= 32'h0;
        end else begin
            bus.dm_we <= 1'b0;
            bus.dm_be <= 4'h0;
            if (accept) begin
                bus.rsp_rd      <= bus.req_rd;
                bus.rsp_is_load <= ~bus.req_we;
                if (illegal) begin
                    bus.rsp_exc      <= 1'b1;
                    bus.rsp_exc_code <= misaligned ? (bus.req_we ? 5'd5 : 5'd4) : 5'd7;
                    bus.rsp_badvaddr <= bus.req_addr;
                    bus.rsp_rdata    <= 32'h0;
                end else begin
                    bus.dm_addr <= bus.req_addr[13:2];
                    bus.dm_be   <= byte_enables(bus.req_size, bus.req_addr[1:0]);
                    bus.dm_din  <= replicate(bus.req_size, bus.req_wdata);
                    bus.dm_we   <= bus.req_we;
                end
            end
            if (state == ACCESS) begin
                bus.rsp_rdata    <= lat_we ? 32'h0 : extend_load(lat_size, lat_uns, bus.dm_dout);
                bus.rsp_exc      <= 1'b0;
                bus.rsp_exc_code <= 5'h0;
                bus.rsp_badvaddr <= 32'h0;
            end
        end
    end

endmodule
